// File: rtl/warp_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : warp_scheduler
// Purpose  : Round-robin warp issue scheduler with per-warp lifecycle and
//            core-done tracking. Optional stats counters: WARP_SCHED_STATS_EN.
// Revision : 1.0
// ============================================================================
module warp_scheduler #(
  parameter int WARPS_PER_CORE = 2,
  parameter int WARP_ID_WIDTH  = (WARPS_PER_CORE > 1) ? $clog2(WARPS_PER_CORE) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [WARPS_PER_CORE-1:0] warp_active_mask,
  input  logic [WARPS_PER_CORE-1:0] warp_ready,
  output logic                      issue_valid,
  output logic [WARP_ID_WIDTH-1:0]  issue_warp_id,
  input  logic                      issue_ready,
  input  logic                      retire_valid,
  input  logic [WARP_ID_WIDTH-1:0]  retire_warp_id,
  input  logic                      retire_last,
  output logic                      done
`ifdef WARP_SCHED_STATS_EN
  ,
  output logic [31:0]               stat_issue_count,
  output logic [31:0]               stat_stall_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUNNING, S_DONE} top_state_e;
  typedef enum logic [1:0] {W_INACTIVE, W_ELIGIBLE, W_INFLIGHT, W_FINISHED} warp_state_e;

  top_state_e               state_q, state_d;
  warp_state_e              warp_q [WARPS_PER_CORE];
  warp_state_e              warp_d [WARPS_PER_CORE];
  logic [WARP_ID_WIDTH-1:0] rr_q, rr_d;
  logic                     lock_q, lock_d;
  logic [WARP_ID_WIDTH-1:0] lock_id_q, lock_id_d;
  logic                     done_q, done_d;

  logic [WARPS_PER_CORE-1:0] cand;
  logic                      any_cand;
  logic [WARP_ID_WIDTH-1:0]  pick_id;
  logic [WARP_ID_WIDTH-1:0]  grant;

  always_comb begin
    for (int i = 0; i < WARPS_PER_CORE; i++) begin
      cand[i] = (warp_q[i] == W_ELIGIBLE) && warp_ready[i];
    end
  end

  // Scan downward so the lowest offset from the rr pointer is written last.
  always_comb begin
    int                       idx;
    logic [WARP_ID_WIDTH-1:0] idx_w;
    any_cand = 1'b0;
    pick_id  = '0;
    idx      = 0;
    idx_w    = '0;
    for (int i = WARPS_PER_CORE - 1; i >= 0; i--) begin
      idx = int'(rr_q) + i;
      if (idx >= WARPS_PER_CORE) idx = idx - WARPS_PER_CORE;
      idx_w = WARP_ID_WIDTH'(idx);
      if (cand[idx_w]) begin
        any_cand = 1'b1;
        pick_id  = idx_w;
      end
    end
  end

  assign grant         = lock_q ? lock_id_q : pick_id;
  assign issue_valid   = (state_q == S_RUNNING) && (lock_q || any_cand);
  assign issue_warp_id = grant;
  assign done          = done_q;

  always_comb begin
    logic all_fin;
    state_d   = state_q;
    warp_d    = warp_q;
    rr_d      = rr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    all_fin   = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUNNING;
          for (int i = 0; i < WARPS_PER_CORE; i++) begin
            warp_d[i] = warp_active_mask[i] ? W_ELIGIBLE : W_FINISHED;
          end
        end
      end
      S_RUNNING: begin
        if (retire_valid && (int'(retire_warp_id) < WARPS_PER_CORE) &&
            (warp_q[retire_warp_id] == W_INFLIGHT)) begin
          warp_d[retire_warp_id] = retire_last ? W_FINISHED : W_ELIGIBLE;
        end
        if (issue_valid) begin
          if (issue_ready) begin
            warp_d[grant] = W_INFLIGHT;
            lock_d        = 1'b0;
            rr_d          = (int'(grant) == WARPS_PER_CORE - 1) ? '0 : grant + 1'b1;
          end else begin
            lock_d    = 1'b1;
            lock_id_d = grant;
          end
        end
        // Checking the next-state view lets a final retire_last reach DONE on its own edge.
        for (int i = 0; i < WARPS_PER_CORE; i++) begin
          if (warp_d[i] != W_FINISHED) all_fin = 1'b0;
        end
        if (all_fin) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      for (int i = 0; i < WARPS_PER_CORE; i++) warp_q[i] <= W_INACTIVE;
      rr_q      <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      warp_q    <= warp_d;
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      done_q    <= done_d;
    end
  end

`ifdef WARP_SCHED_STATS_EN
  logic [31:0] stat_issue_q, stat_issue_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  // issue_valid is only ever high in RUNNING, so DONE freezes both counters.
  always_comb begin
    stat_issue_d = stat_issue_q;
    stat_stall_d = stat_stall_q;
    if (issue_valid && issue_ready && (stat_issue_q != '1)) stat_issue_d = stat_issue_q + 32'd1;
    if (issue_valid && !issue_ready && (stat_stall_q != '1)) stat_stall_d = stat_stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_issue_q <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_issue_q <= stat_issue_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_issue_count = stat_issue_q;
  assign stat_stall_count = stat_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_warp_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_warp_scheduler
// Purpose  : Directed bench for warp_scheduler (4 warps) with a cycle model.
// Revision : 1.0
// ============================================================================
module tb_warp_scheduler;

  localparam int W   = 4;
  localparam int WID = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   warp_active_mask = '0;
  logic [W-1:0]   warp_ready = '0;
  logic           issue_valid;
  logic [WID-1:0] issue_warp_id;
  logic           issue_ready = 1'b0;
  logic           retire_valid = 1'b0;
  logic [WID-1:0] retire_warp_id = '0;
  logic           retire_last = 1'b0;
  logic           done;
`ifdef WARP_SCHED_STATS_EN
  logic [31:0]    stat_issue_count;
  logic [31:0]    stat_stall_count;
`endif

  warp_scheduler #(.WARPS_PER_CORE(W), .WARP_ID_WIDTH(WID)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .warp_active_mask (warp_active_mask),
    .warp_ready       (warp_ready),
    .issue_valid      (issue_valid),
    .issue_warp_id    (issue_warp_id),
    .issue_ready      (issue_ready),
    .retire_valid     (retire_valid),
    .retire_warp_id   (retire_warp_id),
    .retire_last      (retire_last),
    .done             (done)
`ifdef WARP_SCHED_STATS_EN
    ,
    .stat_issue_count (stat_issue_count),
    .stat_stall_count (stat_stall_count)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int grants[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: top 0=idle 1=running 2=done; warp 0=inactive 1=eligible 2=inflight 3=finished
  int          m_top = 0;
  int          m_ws[W] = '{default: 0};
  int          m_rr = 0;
  bit          m_lock = 1'b0;
  int          m_lid = 0;
  logic [31:0] m_issues = 0;
  logic [31:0] m_stalls = 0;

  always @(negedge clk) begin
    bit ev;
    int eid;
    int w;
    bit allfin;
    ev  = 1'b0;
    eid = 0;
    if (m_top == 1) begin
      if (m_lock) begin
        ev  = 1'b1;
        eid = m_lid;
      end else begin
        for (int k = 0; k < W; k++) begin
          w = (m_rr + k) % W;
          if (!ev && m_ws[w] == 1 && warp_ready[w]) begin
            ev  = 1'b1;
            eid = w;
          end
        end
      end
    end
    chk("issue_valid", {31'd0, issue_valid}, {31'd0, ev});
    if (ev) chk("issue_warp_id", {30'd0, issue_warp_id}, eid);
    chk("done", {31'd0, done}, {31'd0, m_top == 2});
`ifdef WARP_SCHED_STATS_EN
    chk("stat_issue_count", stat_issue_count, m_issues);
    chk("stat_stall_count", stat_stall_count, m_stalls);
`endif
    if (ev && issue_ready) grants.push_back(eid);

    if (reset) begin
      m_top = 0; m_rr = 0; m_lock = 1'b0; m_lid = 0; m_issues = 0; m_stalls = 0;
      for (int k = 0; k < W; k++) m_ws[k] = 0;
    end else if (m_top == 0) begin
      if (start) begin
        m_top = 1;
        for (int k = 0; k < W; k++) m_ws[k] = warp_active_mask[k] ? 1 : 3;
      end
    end else if (m_top == 1) begin
      if (retire_valid && m_ws[retire_warp_id] == 2) m_ws[retire_warp_id] = retire_last ? 3 : 1;
      if (ev) begin
        if (issue_ready) begin
          m_ws[eid] = 2; m_lock = 1'b0; m_rr = (eid + 1) % W; m_issues++;
        end else begin
          m_lock = 1'b1; m_lid = eid; m_stalls++;
        end
      end
      allfin = 1'b1;
      for (int k = 0; k < W; k++) if (m_ws[k] != 3) allfin = 1'b0;
      if (allfin) m_top = 2;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; warp_active_mask = '0; warp_ready = '0; issue_ready = 0;
    retire_valid = 0; retire_warp_id = '0; retire_last = 0;
  endtask

  task automatic do_reset();
    reset = 1; idle_inputs(); tick(); tick(); reset = 0; grants.delete();
  endtask

  task automatic retire(input int id, input bit last);
    retire_valid = 1; retire_warp_id = WID'(id); retire_last = last;
  endtask

  task automatic chk_grant(input string name, input int i, input int exp);
    chk(name, (i < grants.size()) ? grants[i] : -1, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    do_reset();
    @(negedge clk);
    chk("reset_valid", {31'd0, issue_valid}, 0);
    chk("reset_id", {30'd0, issue_warp_id}, 0);
    chk("reset_done", {31'd0, done}, 0);
    tick();

    // T1: two active warps, retire each the cycle after issue -> 0,1,0,1
    do_reset();
    warp_active_mask = 4'b0011; warp_ready = 4'b0011; issue_ready = 1; start = 1; tick();
    start = 0;
    for (int k = 0; k < 4; k++) begin
      retire_valid = 0;
      if (k > 0) retire((k - 1) % 2, 0);
      tick();
    end
    warp_ready = '0; retire(1, 0);
    @(negedge clk); chk("t1_done", {31'd0, done}, 0);
    tick();
    retire_valid = 0;
    chk("t1_ngrants", grants.size(), 4);
    for (int i = 0; i < 4; i++) chk_grant("t1_grant", i, i % 2);

    // T2: mask 0101 -> grants 0,2,0,2, then done after both retire_last
    do_reset();
    warp_active_mask = 4'b0101; warp_ready = 4'b0101; issue_ready = 1; start = 1; tick();
    start = 0; tick();
    retire(0, 0); tick();
    retire(2, 0); tick();
    retire(0, 1); tick();
    retire(2, 1);
    @(negedge clk); chk("t2_done_pre", {31'd0, done}, 0);
    tick();
    retire_valid = 0; retire_last = 0;
    @(negedge clk);
    chk("t2_done", {31'd0, done}, 1);
    chk("t2_valid", {31'd0, issue_valid}, 0);
    tick();
    chk("t2_ngrants", grants.size(), 4);
    for (int i = 0; i < 4; i++) chk_grant("t2_grant", i, 2 * (i % 2));

    // T3: hold warp 1 for 3 stall cycles while warp 0 becomes ready
    do_reset();
    warp_active_mask = 4'b0011; warp_ready = 4'b0010; issue_ready = 0; start = 1; tick();
    start = 0;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) warp_ready = 4'b0011;
      @(negedge clk);
      chk("t3_hold_valid", {31'd0, issue_valid}, 1);
      chk("t3_hold_id", {30'd0, issue_warp_id}, 1);
      tick();
    end
    issue_ready = 1;
    @(negedge clk); chk("t3_accept_id", {30'd0, issue_warp_id}, 1);
    tick();
    retire(3, 0);  // warp 3 is FINISHED: must be ignored
    @(negedge clk); chk("t3_next_id", {30'd0, issue_warp_id}, 0);
    tick();
    retire(1, 0); tick();
    retire(0, 0); tick();
    retire_valid = 0; tick();
    retire(1, 0); tick();
    retire_valid = 0; tick();
    warp_ready = '0;
    @(negedge clk);
    chk("t3_done", {31'd0, done}, 0);
`ifdef WARP_SCHED_STATS_EN
    chk("t3_stat_issue", stat_issue_count, 5);
    chk("t3_stat_stall", stat_stall_count, 3);
`endif
    tick();
    chk("t3_ngrants", grants.size(), 5);
    for (int i = 0; i < 5; i++) chk_grant("t3_grant", i, (i % 2 == 0) ? 1 : 0);

    // T4: empty mask -> done two edges after start, start in DONE ignored
    do_reset();
    warp_active_mask = 4'b0000; warp_ready = 4'b1111; issue_ready = 1; start = 1;
    @(negedge clk); chk("t4_valid_c0", {31'd0, issue_valid}, 0);
    tick();
    start = 0;
    @(negedge clk);
    chk("t4_done_c1", {31'd0, done}, 0);
    chk("t4_valid_c1", {31'd0, issue_valid}, 0);
    tick();
    @(negedge clk);
    chk("t4_done_c2", {31'd0, done}, 1);
    chk("t4_valid_c2", {31'd0, issue_valid}, 0);
    tick();
    warp_active_mask = 4'b1111; start = 1;
    @(negedge clk);
    chk("t4_done_restart", {31'd0, done}, 1);
    tick();
    start = 0; tick();
    chk("t4_ngrants", grants.size(), 0);

    // T5: reset with two warps in flight, then fresh start with mask 0010
    do_reset();
    warp_active_mask = 4'b0011; warp_ready = 4'b0011; issue_ready = 1; start = 1; tick();
    start = 0; tick(); tick();
    reset = 1; tick();
    reset = 0; warp_active_mask = 4'b0010; start = 1;
    @(negedge clk);
    chk("t5_valid_after_reset", {31'd0, issue_valid}, 0);
    chk("t5_done_after_reset", {31'd0, done}, 0);
    tick();
    start = 0;
    @(negedge clk);
    chk("t5_valid", {31'd0, issue_valid}, 1);
    chk("t5_id", {30'd0, issue_warp_id}, 1);
    tick();
    retire(1, 1);
    @(negedge clk); chk("t5_valid_inflight", {31'd0, issue_valid}, 0);
    tick();
    retire_valid = 0; retire_last = 0;
    @(negedge clk); chk("t5_done", {31'd0, done}, 1);
    tick();
    chk("t5_ngrants", grants.size(), 3);
    chk_grant("t5_grant", 0, 0);
    chk_grant("t5_grant", 1, 1);
    chk_grant("t5_grant", 2, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
